gl_prim_assembly: RTL and testbench

//  Triangle assembler between the viewport-transform stage and the rasterizer.

---
 rtl/gl_prim_assembly_pkg.sv | 34 +++
 rtl/gl_prim_assembly_tri_out_reg.sv | 59 +++++
 rtl/gl_prim_assembly.sv | 153 +++++++++++++++
 tb/tb_gl_prim_assembly.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gl_prim_assembly_pkg.sv
// gl_prim_assembly_pkg: topology encodings, FSM states and vertex field
// offsets shared by the triangle assembler and its output register.
// Build option: DEGEN_CULL_EN (see gl_prim_assembly.sv).
package gl_prim_assembly_pkg;

  localparam int COORD_W_DEF = 32;
  localparam int NUM_FIELDS  = 6;

  // Topology encodings as seen on prim_mode
  localparam logic [1:0] GL_PRIM_LIST  = 2'b00;
  localparam logic [1:0] GL_PRIM_STRIP = 2'b01;
  localparam logic [1:0] GL_PRIM_FAN   = 2'b10;

  // Field index inside a packed vertex {x,y,z,r,g,b}; x sits in the MSBs
  localparam int FLD_X = 5;
  localparam int FLD_Y = 4;
  localparam int FLD_Z = 3;
  localparam int FLD_R = 2;
  localparam int FLD_G = 1;
  localparam int FLD_B = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT0 = 2'd1,
    ST_WAIT1 = 2'd2,
    ST_WAIT2 = 2'd3
  } state_e;

  // The reserved encoding behaves as a triangle list
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? GL_PRIM_LIST : m;
  endfunction

endpackage

// File: rtl/gl_prim_assembly_tri_out_reg.sv
// gl_tri_out_reg: three-vertex holding register with valid/ready handshake.
// A load is only requested when the slot is empty or being drained, so a
// held triangle is never overwritten.
module gl_tri_out_reg #(
  parameter int VTX_W = 192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [VTX_W-1:0] in_v0,
  input  logic [VTX_W-1:0] in_v1,
  input  logic [VTX_W-1:0] in_v2,
  input  logic             tri_ready,
  output logic             tri_valid,
  output logic [VTX_W-1:0] tri_v0,
  output logic [VTX_W-1:0] tri_v1,
  output logic [VTX_W-1:0] tri_v2
);

  logic             valid_q, valid_d;
  logic [VTX_W-1:0] v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;

  // Next valid/data: load sets, consume clears, otherwise hold
  always_comb begin
    valid_d = valid_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    if (load) begin
      valid_d = 1'b1;
      v0_d    = in_v0;
      v1_d    = in_v1;
      v2_d    = in_v2;
    end else if (valid_q && tri_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      v0_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
    end else begin
      valid_q <= valid_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
    end
  end

  assign tri_valid = valid_q;
  assign tri_v0    = v0_q;
  assign tri_v1    = v1_q;
  assign tri_v2    = v2_q;

endmodule

// File: rtl/gl_prim_assembly.sv
// gl_prim_assembly: groups incoming vertices into list/strip/fan triangles.
// Build option: DEGEN_CULL_EN drops triangles with two identical (x,y)
// positions while still advancing slots and strip parity.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | outside a primitive; accepted vertices are dropped
// ST_WAIT0 | waiting for the first vertex (slot A)
// ST_WAIT1 | waiting for the second vertex (slot B)
// ST_WAIT2 | each further vertex completes a triangle
module gl_prim_assembly
  import gl_prim_assembly_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int VTX_W   = NUM_FIELDS * COORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prim_begin,
  input  logic             prim_end,
  input  logic [1:0]       prim_mode,
  input  logic             vtx_valid,
  output logic             vtx_ready,
  input  logic [VTX_W-1:0] vtx_data,
  output logic             tri_valid,
  input  logic             tri_ready,
  output logic [VTX_W-1:0] tri_v0,
  output logic [VTX_W-1:0] tri_v1,
  output logic [VTX_W-1:0] tri_v2,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             parity_q, parity_d;
  logic [VTX_W-1:0] slot_a_q, slot_a_d, slot_b_q, slot_b_d;

  logic             accept;
  logic             emit;
  logic             load;
  logic [VTX_W-1:0] e0, e1, e2;

  assign vtx_ready = !tri_valid || tri_ready;
  assign accept    = vtx_valid && vtx_ready;

  // Vertex processing first, then any begin/end state change on top
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    parity_d = parity_q;
    slot_a_d = slot_a_q;
    slot_b_d = slot_b_q;
    emit     = 1'b0;
    e0       = slot_a_q;
    e1       = slot_b_q;
    e2       = vtx_data;

    if (accept) begin
      case (state_q)
        ST_WAIT0: begin
          slot_a_d = vtx_data;
          state_d  = ST_WAIT1;
        end
        ST_WAIT1: begin
          slot_b_d = vtx_data;
          state_d  = ST_WAIT2;
        end
        ST_WAIT2: begin
          emit = 1'b1;
          case (mode_q)
            GL_PRIM_STRIP: begin
              if (parity_q) begin
                e0 = slot_b_q;
                e1 = slot_a_q;
              end
              slot_a_d = slot_b_q;
              slot_b_d = vtx_data;
              parity_d = !parity_q;
            end
            GL_PRIM_FAN: begin
              slot_b_d = vtx_data;
            end
            default: begin
              state_d = ST_WAIT0;
            end
          endcase
        end
        default: ;
      endcase
    end

    if (prim_begin) begin
      state_d  = ST_WAIT0;
      mode_d   = norm_mode(prim_mode);
      parity_d = 1'b0;
    end else if (prim_end && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end
  end

`ifdef DEGEN_CULL_EN
  logic [2*COORD_W-1:0] xy0, xy1, xy2;
  logic                 degen;

  // Two coincident screen positions give a zero-area triangle
  always_comb begin
    xy0   = {e0[FLD_X*COORD_W +: COORD_W], e0[FLD_Y*COORD_W +: COORD_W]};
    xy1   = {e1[FLD_X*COORD_W +: COORD_W], e1[FLD_Y*COORD_W +: COORD_W]};
    xy2   = {e2[FLD_X*COORD_W +: COORD_W], e2[FLD_Y*COORD_W +: COORD_W]};
    degen = (xy0 == xy1) || (xy0 == xy2) || (xy1 == xy2);
  end

  assign load = emit && !degen;
`else
  assign load = emit;
`endif

  // FSM, latched topology, strip parity and vertex slots
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= GL_PRIM_LIST;
      parity_q <= 1'b0;
      slot_a_q <= '0;
      slot_b_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      parity_q <= parity_d;
      slot_a_q <= slot_a_d;
      slot_b_q <= slot_b_d;
    end
  end

  gl_tri_out_reg #(
    .VTX_W(VTX_W)
  ) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .in_v0     (e0),
    .in_v1     (e1),
    .in_v2     (e2),
    .tri_ready (tri_ready),
    .tri_valid (tri_valid),
    .tri_v0    (tri_v0),
    .tri_v1    (tri_v1),
    .tri_v2    (tri_v2)
  );

  assign busy = (state_q != ST_IDLE) || tri_valid;

endmodule

// File: tb/tb_gl_prim_assembly.sv
`timescale 1ns/1ps
module tb_gl_prim_assembly;

  localparam int COORD_W = 32;
  localparam int VTX_W   = 6 * COORD_W;
  localparam int TRI_W   = 3 * VTX_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             prim_begin = 1'b0;
  logic             prim_end = 1'b0;
  logic [1:0]       prim_mode = 2'b00;
  logic             vtx_valid = 1'b0;
  logic             vtx_ready;
  logic [VTX_W-1:0] vtx_data = '0;
  logic             tri_valid;
  logic             tri_ready = 1'b1;
  logic [VTX_W-1:0] tri_v0, tri_v1, tri_v2;
  logic             busy;

  int tests  = 0;
  int failed = 0;

  logic [TRI_W-1:0] got[$];

  gl_prim_assembly #(.COORD_W(COORD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .prim_begin (prim_begin),
    .prim_end   (prim_end),
    .prim_mode  (prim_mode),
    .vtx_valid  (vtx_valid),
    .vtx_ready  (vtx_ready),
    .vtx_data   (vtx_data),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .tri_v0     (tri_v0),
    .tri_v1     (tri_v1),
    .tri_v2     (tri_v2),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Record every triangle that will be consumed at the coming posedge
  always @(negedge clk) begin
    if (!reset && tri_valid && tri_ready) got.push_back({tri_v0, tri_v1, tri_v2});
  end

  function automatic logic [VTX_W-1:0] mkv(input int i);
    return {32'(i * 17), 32'(i + 1000), 32'(i * 3), 32'(i + 7), 32'(i + 9), 32'(i + 11)};
  endfunction

  function automatic logic [TRI_W-1:0] mkt(input int a, input int b, input int c);
    return {mkv(a), mkv(b), mkv(c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [VTX_W-1:0] v);
    int cnt;
    cnt = 0;
    vtx_valid = 1'b1;
    vtx_data  = v;
    while (1) begin
      @(negedge clk);
      if (vtx_ready) break;
      cnt++;
      if (cnt > 50) begin
        tests++;
        failed++;
        $display("FAIL send_timeout: vtx_ready=%0b required=1", vtx_ready);
        vtx_valid = 1'b0;
        return;
      end
    end
    tick();
    vtx_valid = 1'b0;
  endtask

  task automatic begin_prim(input logic [1:0] m);
    prim_begin = 1'b1;
    prim_mode  = m;
    tick();
    prim_begin = 1'b0;
    prim_mode  = 2'b11;
  endtask

  task automatic end_prim();
    prim_end = 1'b1;
    tick();
    prim_end = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests++; if (tri_valid !== 1'b0) begin failed++; $display("FAIL reset_tri_valid: got %0b required 0", tri_valid); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b required 0", busy); end
    tests++; if (tri_v0 !== '0 || tri_v1 !== '0 || tri_v2 !== '0) begin failed++; $display("FAIL reset_tri_v: got %h required 0", tri_v0); end
    tests++; if (vtx_ready !== 1'b1) begin failed++; $display("FAIL reset_vtx_ready: got %0b required 1", vtx_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_list();
    logic [TRI_W-1:0] exp_t[2];
    exp_t[0] = mkt(1, 2, 3);
    exp_t[1] = mkt(4, 5, 6);
    got.delete();
    begin_prim(2'b00);
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL list_busy: got %0b required 1", busy); end
    send(mkv(1));
    send(mkv(2));
    tests++; if (tri_valid !== 1'b0) begin failed++; $display("FAIL list_early_valid: got %0b required 0", tri_valid); end
    send(mkv(3));
    tests++; if (tri_valid !== 1'b1 || tri_v0 !== mkv(1)) begin failed++; $display("FAIL list_latency_v3: valid %0b v0 %h required 1 %h", tri_valid, tri_v0, mkv(1)); end
    send(mkv(4));
    send(mkv(5));
    send(mkv(6));
    tests++; if (tri_valid !== 1'b1 || tri_v2 !== mkv(6)) begin failed++; $display("FAIL list_latency_v6: valid %0b v2 %h required 1 %h", tri_valid, tri_v2, mkv(6)); end
    end_prim();
    drain();
    tests++; if (got.size() != 2) begin failed++; $display("FAIL list_count: got %0d required 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      tests++; if (got[i] !== exp_t[i]) begin failed++; $display("FAIL list_tri%0d: got %h required %h", i, got[i], exp_t[i]); end
    end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL list_busy_end: got %0b required 0", busy); end
  endtask

  task automatic test_strip();
    logic [TRI_W-1:0] exp_t[3];
    exp_t[0] = mkt(1, 2, 3);
    exp_t[1] = mkt(3, 2, 4);
    exp_t[2] = mkt(3, 4, 5);
    got.delete();
    begin_prim(2'b01);
    for (int i = 1; i <= 5; i++) send(mkv(i));
    end_prim();
    drain();
    tests++; if (got.size() != 3) begin failed++; $display("FAIL strip_count: got %0d required 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      tests++; if (got[i] !== exp_t[i]) begin failed++; $display("FAIL strip_tri%0d: got %h required %h", i, got[i], exp_t[i]); end
    end
  endtask

  task automatic test_fan();
    logic [TRI_W-1:0] exp_t[3];
    exp_t[0] = mkt(1, 2, 3);
    exp_t[1] = mkt(1, 3, 4);
    exp_t[2] = mkt(1, 4, 5);
    got.delete();
    begin_prim(2'b10);
    for (int i = 1; i <= 5; i++) send(mkv(i));
    end_prim();
    drain();
    tests++; if (got.size() != 3) begin failed++; $display("FAIL fan_count: got %0d required 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      tests++; if (got[i] !== exp_t[i]) begin failed++; $display("FAIL fan_tri%0d: got %h required %h", i, got[i], exp_t[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [TRI_W-1:0] exp_t[2];
    exp_t[0] = mkt(1, 2, 3);
    exp_t[1] = mkt(4, 5, 6);
    got.delete();
    begin_prim(2'b00);
    tri_ready = 1'b0;
    send(mkv(1));
    send(mkv(2));
    send(mkv(3));
    vtx_valid = 1'b1;
    vtx_data  = mkv(4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++; if (vtx_ready !== 1'b0) begin failed++; $display("FAIL bp_vtx_ready%0d: got %0b required 0", c, vtx_ready); end
      tests++; if (tri_valid !== 1'b1 || {tri_v0, tri_v1, tri_v2} !== exp_t[0]) begin failed++; $display("FAIL bp_hold%0d: valid %0b v0 %h required 1 %h", c, tri_valid, tri_v0, mkv(1)); end
    end
    tick();
    tri_ready = 1'b1;
    send(mkv(4));
    send(mkv(5));
    send(mkv(6));
    end_prim();
    drain();
    tests++; if (got.size() != 2) begin failed++; $display("FAIL bp_count: got %0d required 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      tests++; if (got[i] !== exp_t[i]) begin failed++; $display("FAIL bp_tri%0d: got %h required %h", i, got[i], exp_t[i]); end
    end
  endtask

  task automatic test_prim_end();
    got.delete();
    begin_prim(2'b00);
    send(mkv(1));
    send(mkv(2));
    end_prim();
    begin_prim(2'b00);
    send(mkv(3));
    send(mkv(4));
    send(mkv(5));
    end_prim();
    drain();
    tests++; if (got.size() != 1) begin failed++; $display("FAIL end_count: got %0d required 1", got.size()); end
    if (got.size() > 0) begin
      tests++; if (got[0] !== mkt(3, 4, 5)) begin failed++; $display("FAIL end_tri: got %h required %h", got[0], mkt(3, 4, 5)); end
    end
  endtask

  task automatic test_back_to_back();
    // Third vertex arrives together with a new prim_begin: triangle still formed
    got.delete();
    begin_prim(2'b00);
    send(mkv(1));
    send(mkv(2));
    vtx_valid  = 1'b1;
    vtx_data   = mkv(3);
    prim_begin = 1'b1;
    prim_mode  = 2'b10;
    tick();
    vtx_valid  = 1'b0;
    prim_begin = 1'b0;
    prim_mode  = 2'b00;
    for (int i = 4; i <= 7; i++) send(mkv(i));
    end_prim();
    drain();
    tests++; if (got.size() != 3) begin failed++; $display("FAIL b2b_count: got %0d required 3", got.size()); end
    if (got.size() == 3) begin
      tests++; if (got[0] !== mkt(1, 2, 3)) begin failed++; $display("FAIL b2b_tri0: got %h required %h", got[0], mkt(1, 2, 3)); end
      tests++; if (got[1] !== mkt(4, 5, 6)) begin failed++; $display("FAIL b2b_tri1: got %h required %h", got[1], mkt(4, 5, 6)); end
      tests++; if (got[2] !== mkt(4, 6, 7)) begin failed++; $display("FAIL b2b_tri2: got %h required %h", got[2], mkt(4, 6, 7)); end
    end
  endtask

  task automatic test_reset_mid();
    got.delete();
    begin_prim(2'b01);
    tri_ready = 1'b0;
    send(mkv(1));
    send(mkv(2));
    send(mkv(3));
    tests++; if (tri_valid !== 1'b1) begin failed++; $display("FAIL rm_pre_valid: got %0b required 1", tri_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (tri_valid !== 1'b0) begin failed++; $display("FAIL rm_tri_valid: got %0b required 0", tri_valid); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rm_busy: got %0b required 0", busy); end
    tri_ready = 1'b1;
    for (int i = 4; i <= 6; i++) send(mkv(i));
    drain();
    tests++; if (got.size() != 0) begin failed++; $display("FAIL rm_idle_drop: got %0d required 0", got.size()); end
  endtask

  task automatic test_degen();
    got.delete();
    begin_prim(2'b00);
    send(mkv(1));
    send(mkv(1));
    send(mkv(2));
    end_prim();
    drain();
`ifdef DEGEN_CULL_EN
    tests++; if (got.size() != 0) begin failed++; $display("FAIL degen_count: got %0d required 0", got.size()); end
`else
    tests++; if (got.size() != 1) begin failed++; $display("FAIL degen_count: got %0d required 1", got.size()); end
    if (got.size() > 0) begin
      tests++; if (got[0] !== mkt(1, 1, 2)) begin failed++; $display("FAIL degen_tri: got %h required %h", got[0], mkt(1, 1, 2)); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_list();
    test_strip();
    test_fan();
    test_backpressure();
    test_prim_end();
    test_back_to_back();
    test_reset_mid();
    test_degen();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
